// File: rtl/ritc_idelay_interface_pkg.sv
// Shared constants and types for the RITC IDELAY register front-end.
package ritc_idelay_interface_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned TAP_W  = 5;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned RDY_W  = DATA_W - TAP_W;

    localparam logic REG_TAP_ADDR  = 1'b0;
    localparam logic REG_TAP_VALUE = 1'b1;

    localparam logic [3:0] CLK_BIT_SEL = 4'hF;

    typedef enum logic [1:0] {
        CH0     = 2'b00,
        CH1     = 2'b01,
        CH2     = 2'b10,
        CH_NONE = 2'b11
    } ritc_ch_e;

    typedef struct packed {
        ritc_ch_e   ch;
        logic [3:0] bit_sel;
    } tap_sel_t;

endpackage

// File: rtl/ritc_idelay_interface_if.sv
// Software-facing register bus of the IDELAY front-end.
interface ritc_idelay_interface_if;
    import ritc_idelay_interface_pkg::*;

    logic              user_sel_i;
    logic              user_addr_i;
    logic [DATA_W-1:0] user_dat_i;
    logic [DATA_W-1:0] user_dat_o;
    logic              user_wr_i;
    logic              user_rd_i;

    modport master (
        output user_sel_i, user_addr_i, user_dat_i, user_wr_i, user_rd_i,
        input  user_dat_o
    );

    modport slave (
        input  user_sel_i, user_addr_i, user_dat_i, user_wr_i, user_rd_i,
        output user_dat_o
    );
endinterface

// File: rtl/ritc_sync_ff.sv
// Multi-bit, multi-stage flip-flop synchroniser for quasi-static inputs.
module ritc_sync_ff #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             CLK,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge CLK) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ritc_idelay_interface.sv
// Two-register user-bus front-end driving IDELAYE2 tap address/value and load strobe,
// with synchronised IDELAYCTRL ready readback.
module ritc_idelay_interface
    import ritc_idelay_interface_pkg::*;
#(
    parameter int unsigned NUM_CTRL    = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  rst_i,
    ritc_idelay_interface_if.slave bus,
    input  logic [NUM_CTRL-1:0]   ready_i,
    output logic [TAP_W-1:0]      delay_o,
    output logic [ADDR_W-1:0]     addr_o,
    output logic                  load_o
);

    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [TAP_W-1:0]    delay_q, delay_d;
    logic                load_q,  load_d;
    logic [NUM_CTRL-1:0] ready_sync;
    logic [RDY_W-1:0]    ready_rd;
    logic                wr_en;

    ritc_sync_ff #(
        .WIDTH  (NUM_CTRL),
        .STAGES (SYNC_STAGES)
    ) u_ready_sync (
        .CLK   (CLK),
        .rst_i (rst_i),
        .d_i   (ready_i),
        .q_o   (ready_sync)
    );

    assign wr_en = bus.user_sel_i && bus.user_wr_i;

    // Write decode; a tap-value write also fires the single-cycle load strobe.
    always_comb begin
        addr_d  = addr_q;
        delay_d = delay_q;
        load_d  = 1'b0;
        if (wr_en) begin
            if (bus.user_addr_i == REG_TAP_ADDR) begin
                addr_d = bus.user_dat_i[ADDR_W-1:0];
            end else begin
                delay_d = bus.user_dat_i[TAP_W-1:0];
                load_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst_i) begin
            addr_q  <= '0;
            delay_q <= '0;
            load_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            delay_q <= delay_d;
            load_q  <= load_d;
        end
    end

    assign ready_rd = RDY_W'(ready_sync);

    // Side-effect-free combinational readback.
    always_comb begin
        bus.user_dat_o = '0;
        if (bus.user_addr_i == REG_TAP_VALUE) begin
            bus.user_dat_o = {ready_rd, delay_q};
        end else begin
            bus.user_dat_o = DATA_W'(addr_q);
        end
    end

    assign addr_o  = addr_q;
    assign delay_o = delay_q;
    assign load_o  = load_q;

    logic unused_c;
    assign unused_c = ^{bus.user_rd_i, bus.user_dat_i[DATA_W-1:ADDR_W]};

endmodule

// File: tb/tb_ritc_idelay_interface.sv
// Self-checking bench for ritc_idelay_interface against a register-level reference model.
module tb_ritc_idelay_interface;

    logic       clk;
    logic       rst;
    logic [2:0] ready;
    logic [4:0] delay_o;
    logic [5:0] addr_o;
    logic       load_o;

    int n_assert = 0;
    int n_fail   = 0;

    int m_addr;
    int m_delay;
    int m_load;
    int m_hist[$];

    ritc_idelay_interface_if usr ();

    ritc_idelay_interface #(
        .NUM_CTRL    (3),
        .SYNC_STAGES (2)
    ) dut (
        .CLK     (clk),
        .rst_i   (rst),
        .bus     (usr.slave),
        .ready_i (ready),
        .delay_o (delay_o),
        .addr_o  (addr_o),
        .load_o  (load_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_read(input int a);
        // Ready readback is the value sampled two edges earlier, above the 5-bit tap value.
        if (a == 0) return m_addr;
        return m_hist[0] * 32 + m_delay;
    endfunction

    task automatic drive(input bit sel, input bit wr, input bit rd, input bit a, input int d);
        usr.user_sel_i  = sel;
        usr.user_wr_i   = wr;
        usr.user_rd_i   = rd;
        usr.user_addr_i = a;
        usr.user_dat_i  = 8'(d);
    endtask

    // One clock: check pre-edge readback, advance model, then check registered outputs.
    task automatic tick();
        bit wr_now;
        #1;
        check("rd_pre", int'(usr.user_dat_o), model_read(int'(usr.user_addr_i)));
        wr_now = usr.user_sel_i && usr.user_wr_i;
        if (rst) begin
            m_addr  = 0;
            m_delay = 0;
            m_load  = 0;
            m_hist  = '{0, 0};
        end else begin
            m_load = (wr_now && usr.user_addr_i) ? 1 : 0;
            if (wr_now && usr.user_addr_i)  m_delay = int'(usr.user_dat_i) % 32;
            if (wr_now && !usr.user_addr_i) m_addr  = int'(usr.user_dat_i) % 64;
            m_hist.push_back(int'(ready));
            void'(m_hist.pop_front());
        end
        @(posedge clk);
        #1;
        check("addr_o",  int'(addr_o),  m_addr);
        check("delay_o", int'(delay_o), m_delay);
        check("load_o",  int'(load_o),  m_load);
        check("rd_post", int'(usr.user_dat_o), model_read(int'(usr.user_addr_i)));
    endtask

    task automatic wr_reg(input bit a, input int d);
        drive(1'b1, 1'b1, 1'b0, a, d);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        m_hist = '{0, 0};
        m_addr = 0; m_delay = 0; m_load = 0;
        rst   = 1'b1;
        ready = 3'b000;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(posedge clk);
        tick();
        tick();
        check("reset_addr",  int'(addr_o),  0);
        check("reset_delay", int'(delay_o), 0);
        check("reset_load",  int'(load_o),  0);
        rst = 1'b0;
        tick();

        wr_reg(1'b0, 8'h1F);
        check("addr_1f", int'(addr_o), 8'h1F);
        check("no_load_addr_wr", int'(load_o), 0);
        wr_reg(1'b1, 8'h0A);
        check("delay_0a", int'(delay_o), 8'h0A);
        check("load_pulse", int'(load_o), 1);
        tick();
        check("load_drop", int'(load_o), 0);

        wr_reg(1'b0, 8'hFF);
        check("addr_mask", int'(addr_o), 8'h3F);
        usr.user_addr_i = 1'b0;
        #1 check("rd_addr_3f", int'(usr.user_dat_o), 8'h3F);
        wr_reg(1'b1, 8'h7F);
        check("delay_mask", int'(delay_o), 8'h1F);
        check("load_7f", int'(load_o), 1);
        tick();
        wr_reg(1'b1, 8'h0A);
        tick();

        ready = 3'b101;
        usr.user_addr_i = 1'b1;
        tick();
        check("rdy_1cyc", int'(usr.user_dat_o), 8'h0A);
        tick();
        check("rdy_2cyc", int'(usr.user_dat_o), 8'hAA);

        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h15);
        tick();
        check("nosel_delay", int'(delay_o), 8'h0A);
        check("nosel_load",  int'(load_o),  0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h15);
        tick();
        check("nosel_addr", int'(addr_o), 8'h3F);

        // Read and write the same register in one cycle.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h2A);
        #1 check("rdwr_pre", int'(usr.user_dat_o), 8'h3F);
        tick();
        check("rdwr_post", int'(usr.user_dat_o), 8'h2A);

        wr_reg(1'b1, 8'h05);
        rst = 1'b1;
        tick();
        check("rst_mid_load",  int'(load_o),  0);
        check("rst_mid_delay", int'(delay_o), 0);
        check("rst_mid_addr",  int'(addr_o),  0);
        rst = 1'b0;
        ready = 3'b000;
        tick();

        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h03);
        tick();
        check("b2b_delay0", int'(delay_o), 3);
        check("b2b_load0",  int'(load_o),  1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h04);
        tick();
        check("b2b_delay1", int'(delay_o), 4);
        check("b2b_load1",  int'(load_o),  1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
        tick();
        check("b2b_end", int'(load_o), 0);

        wr_reg(1'b0, 8'h3C);
        check("ch3_stored", int'(addr_o), 8'h3C);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            ready = 3'($urandom_range(0, 7));
            rst   = ($urandom_range(0, 31) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
